// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the e5/f1.15 floating-point word used by the
// floor pipe and its arbiter.
//   FP_W      - total word width {exp, frac}
//   FP_EXP_W  - exponent field width
//   FP_FRAC_W - fraction field width (1.15 fixed point, explicit leading bit)
//   FP_BIAS   - exponent bias
//   fp_id_w() - requester-ID width for a given requester count (minimum 1)
package fp_pkg;

    localparam int FP_W      = 21;
    localparam int FP_EXP_W  = 5;
    localparam int FP_FRAC_W = 16;
    localparam int FP_BIAS   = 15;

    typedef logic [FP_W-1:0] fp_word_t;

    function automatic int fp_id_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fp_floor.sv
// fp_floor: combinational floor of an e5/f1.15 value {exp[4:0], frac[15:0]}.
//   i_op  - operand word
//   o_res - floored word; exponent passes through unchanged
// Exponent below the bias means |x| < 1, so the fraction is cleared. For
// exponents bias..2*bias the fractional bits below the binary point are
// cleared; exponent all-ones carries no usable fraction and is cleared too.
import fp_pkg::*;

module fp_floor (
    input  logic [FP_W-1:0] i_op,
    output logic [FP_W-1:0] o_res
);

    logic [FP_EXP_W-1:0]  w_exp;
    logic [FP_FRAC_W-1:0] w_frac;
    logic [FP_EXP_W-1:0]  w_sh;
    logic [FP_FRAC_W-1:0] w_mask;
    logic [FP_FRAC_W-1:0] w_frac_out;

    assign w_exp  = i_op[FP_W-1:FP_FRAC_W];
    assign w_frac = i_op[FP_FRAC_W-1:0];

    always_comb begin
        w_sh       = '0;
        w_mask     = '1;
        w_frac_out = '0;
        if (w_exp < FP_EXP_W'(FP_BIAS)) begin
            w_frac_out = '0;
        end else if (w_exp == '1) begin
            w_frac_out = '0;
        end else begin
            // number of bits below the binary point: 2*bias - exp (0..15)
            w_sh       = FP_EXP_W'(2 * FP_BIAS) - w_exp;
            w_mask     = {FP_FRAC_W{1'b1}} << w_sh;
            w_frac_out = w_frac & w_mask;
        end
    end

    assign o_res = {w_exp, w_frac_out};

endmodule

// File: rtl/fp_rr_pick.sv
// fp_rr_pick: combinational round-robin picker.
//   i_req - request vector
//   i_ptr - highest-priority index this cycle
//   o_gnt - one-hot grant (first set bit of i_req scanning upward from i_ptr)
//   o_idx - index of the granted bit
//   o_any - high when any request is granted
import fp_pkg::*;

module fp_rr_pick #(
    parameter int P_NREQ = 2,
    parameter int P_IDW  = 1
) (
    input  logic [P_NREQ-1:0] i_req,
    input  logic [P_IDW-1:0]  i_ptr,
    output logic [P_NREQ-1:0] o_gnt,
    output logic [P_IDW-1:0]  o_idx,
    output logic              o_any
);

    logic [2*P_NREQ-1:0] w_dbl;
    logic [P_NREQ-1:0]   w_rot;
    logic [P_IDW:0]      w_off;
    logic [P_IDW:0]      w_sum;
    logic                w_found;

    // Rotate so that the pointer position lands at bit 0; the pointer is
    // always < P_NREQ, so the doubled vector covers the wrap-around.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[P_NREQ-1:0];

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int unsigned i = 0; i < P_NREQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = (P_IDW+1)'(i);
            end
        end
    end

    // Map the rotated offset back to an absolute index, mod P_NREQ.
    always_comb begin
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= (P_IDW+1)'(P_NREQ)) begin
            w_sum = w_sum - (P_IDW+1)'(P_NREQ);
        end
    end

    assign o_any = w_found;
    assign o_idx = w_sum[P_IDW-1:0];
    assign o_gnt = w_found ? (P_NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/fp_floor_arb.sv
// fp_floor_arb: round-robin shares one fp_floor datapath between P_NREQ
// requesters behind a single registered, back-pressurable result stage.
//   i_clk       - core clock
//   i_rst       - synchronous, active-high reset
//   i_req_valid - per-requester request valid
//   i_req_data  - operands, requester k at bits [21k+20:21k]
//   o_req_ready - one-hot accept; transfer on valid&ready of the same bit
//   o_res_valid - result valid
//   o_res_data  - floored value {exp, frac}
//   o_res_id    - requester index that issued the result
//   i_res_ready - consumer accepts result
//   o_busy      - result held or any request pending
import fp_pkg::*;

module fp_floor_arb #(
    parameter int P_NREQ = 2,
    parameter int P_IDW  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [P_NREQ-1:0]      i_req_valid,
    input  logic [FP_W*P_NREQ-1:0] i_req_data,
    output logic [P_NREQ-1:0]      o_req_ready,
    output logic                   o_res_valid,
    output logic [FP_W-1:0]        o_res_data,
    output logic [P_IDW-1:0]       o_res_id,
    input  logic                   i_res_ready,
    output logic                   o_busy
);

    logic                r_res_valid;
    logic [FP_W-1:0]     r_res_data;
    logic [P_IDW-1:0]    r_res_id;
    logic [P_IDW-1:0]    r_rr_ptr;

    logic                w_can_load;
    logic [P_NREQ-1:0]   w_req_elig;
    logic [P_NREQ-1:0]   w_gnt;
    logic [P_IDW-1:0]    w_idx;
    logic                w_any;
    logic [FP_W-1:0]     w_op;
    logic [FP_W-1:0]     w_floor;
    logic [P_IDW:0]      w_nxt;

    assign w_can_load = !r_res_valid || i_res_ready;

    // Nothing is offered to the picker while in reset or while the result
    // register is blocked, so o_req_ready is zero in those cycles.
    assign w_req_elig = (w_can_load && !i_rst) ? i_req_valid : '0;

    fp_rr_pick #(
        .P_NREQ (P_NREQ),
        .P_IDW  (P_IDW)
    ) u_pick (
        .i_req (w_req_elig),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // One-hot AND-OR operand mux.
    always_comb begin
        w_op = '0;
        for (int unsigned k = 0; k < P_NREQ; k++) begin
            w_op = w_op | ({FP_W{w_gnt[k]}} & i_req_data[k*FP_W +: FP_W]);
        end
    end

    fp_floor u_floor (
        .i_op  (w_op),
        .o_res (w_floor)
    );

    assign w_nxt = {1'b0, w_idx} + (P_IDW+1)'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_any) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_floor;
            r_res_id    <= w_idx;
            r_rr_ptr    <= (w_nxt == (P_IDW+1)'(P_NREQ)) ? '0 : w_nxt[P_IDW-1:0];
        end else if (i_res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign o_req_ready = w_gnt;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_id    = r_res_id;
    assign o_busy      = r_res_valid || (|i_req_valid);

endmodule
